// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter, LSB first, fixed baud from CLOCKS_PER_BAUD.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_uart,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [23:0] RELOAD = 24'(CLOCKS_PER_BAUD - 1);

  logic [2:0]  state;
  logic [23:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  assign dbg_state = state;

  // Handshake: a byte is accepted when i_wr is high at a rising edge while
  // o_busy (registered) is low; i_wr during busy is dropped, nothing queued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      baud_cnt <= 24'd0;
      bit_idx  <= 3'd0;
      shift_q  <= 8'd0;
      o_uart   <= 1'b1;
      o_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_wr) begin
            shift_q  <= i_data;
            baud_cnt <= RELOAD;
            state    <= START;
            o_uart   <= 1'b0;
            o_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^i_data;
`endif
          end
        end
        START: begin
          if (baud_cnt == 24'd0) begin
            baud_cnt <= RELOAD;
            bit_idx  <= 3'd0;
            state    <= DATA;
            o_uart   <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        DATA: begin
          if (baud_cnt == 24'd0) begin
            baud_cnt <= RELOAD;
            shift_q  <= shift_q >> 1;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              o_uart <= parity_q;
`else
              state  <= STOP;
              o_uart <= 1'b1;
`endif
            end else begin
              // Output the next bit now so the line changes on the advance edge.
              o_uart <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_cnt == 24'd0) begin
            baud_cnt <= RELOAD;
            state    <= STOP;
            o_uart   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == 24'd0) begin
            baud_cnt <= RELOAD;
            state    <= IDLE;
            o_uart   <= 1'b1;
            o_busy   <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        default: begin
          state  <= IDLE;
          o_uart <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
